// File: rtl/fetch_control.sv
// Fetch-side control: IF/ID register, JAL/EX redirect, load-use stall and HALT drain FSM.
// Optional FETCH_PERF_COUNTERS_EN adds stall_count/flush_count outputs.
module fetch_control #(
    parameter logic [31:0] NOP_INSTR    = 32'h00000013,
    parameter logic [6:0]  HALT_OPCODE  = 7'h7F,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        bubble,
    input  logic [31:0] PC,
    input  logic [31:0] nextPC,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    output logic        hlt,
    output logic        jump,
    output logic [31:0] next,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_PC,
    output logic [31:0] id_nextPC,
    output logic        id_bubble,
    output logic        halt_done,
    output logic [1:0]  fsm_state
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    // Handshake: the program server treats stall as "hold PC and re-serve" and
    // jump/next as a same-cycle redirect; no valid/ready pairs exist on this side.

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   drain_cnt, drain_cnt_nxt;
    logic               hlt_nxt;

    logic [6:0]  opc;
    logic [4:0]  rs1, rs2;
    logic        rs1_used, rs2_used;
    logic        is_jal, is_halt;
    logic [20:0] jal_imm;
    logic [31:0] jal_word_off;
    logic [31:0] jal_target;

    assign opc = id_instruction[6:0];
    assign rs1 = id_instruction[19:15];
    assign rs2 = id_instruction[24:20];

    assign rs1_used = !((opc == 7'h37) || (opc == 7'h17) || (opc == 7'h6F) || (opc == HALT_OPCODE));
    assign rs2_used = (opc == 7'h33) || (opc == 7'h23) || (opc == 7'h63);

    assign is_jal  = id_valid && (opc == 7'h6F);
    assign is_halt = id_valid && (opc == HALT_OPCODE);

    // Byte offset is even; the PC is a word address, so drop two bits arithmetically.
    assign jal_imm      = {id_instruction[31], id_instruction[19:12], id_instruction[20],
                           id_instruction[30:21], 1'b0};
    assign jal_word_off = {{13{jal_imm[20]}}, jal_imm[20:2]};
    assign jal_target   = id_PC + jal_word_off;

    always_comb begin
        stall = 1'b0;
        jump  = 1'b0;
        next  = 32'd0;
        if (!ex_branch_taken && id_valid && ex_mem_read && (ex_rd != 5'd0)) begin
            stall = (rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd));
        end
        // The EX instruction is older, so its redirect squashes a JAL sitting in ID.
        if (ex_branch_taken) begin
            jump = 1'b1;
            next = ex_target;
        end else if (is_jal && (state == ST_RUN)) begin
            jump = 1'b1;
            next = jal_target;
        end
    end

    assign id_bubble = stall;
    assign halt_done = (state == ST_HALTED);
    assign fsm_state = state;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        hlt_nxt       = hlt;
        unique case (state)
            ST_RUN: begin
                if (is_halt && !ex_branch_taken) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = '0;
                    hlt_nxt       = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_cnt_nxt = drain_cnt + 1'b1;
                if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            hlt       <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            hlt       <= hlt_nxt;
        end
    end

    // IF/ID register: flush beats stall, stall beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
            id_PC          <= 32'd0;
            id_nextPC      <= 32'd0;
        end else if (jump || (state != ST_RUN)) begin
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (!stall) begin
            id_instruction <= instruction;
            id_valid       <= !bubble;
            id_PC          <= PC;
            id_nextPC      <= nextPC;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else if (state == ST_RUN) begin
            if (stall) stall_count <= stall_count + 32'd1;
            if (jump)  flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed test-plan scenarios plus randomized traffic
// checked every cycle against a behavioural model of the fetch/halt rules.
module tb_fetch_control;

    localparam logic [31:0] NOP          = 32'h00000013;
    localparam int          DRAIN_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        bubble = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] nextPC = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        hlt, jump, stall, id_valid, id_bubble, halt_done;
    logic [31:0] next, id_instruction, id_PC, id_nextPC;
    logic [1:0]  fsm_state;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_count, flush_count;
`endif

    fetch_control dut (
        .clk(clk), .rst(rst), .instruction(instruction), .bubble(bubble),
        .PC(PC), .nextPC(nextPC), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
        .hlt(hlt), .jump(jump), .next(next), .stall(stall), .id_valid(id_valid),
        .id_instruction(id_instruction), .id_PC(id_PC), .id_nextPC(id_nextPC),
        .id_bubble(id_bubble), .halt_done(halt_done), .fsm_state(fsm_state)
`ifdef FETCH_PERF_COUNTERS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: IF/ID contents plus "cycles since halt accepted" (-1 = running).
    logic [31:0] m_instr = NOP, m_pc = '0, m_npc = '0;
    logic        m_valid = 1'b0;
    int          m_age = -1;
    logic [31:0] m_sc = '0, m_fc = '0;

    logic        e_stall, e_jump;
    logic [31:0] e_next;

    always_comb begin
        logic [6:0] op;
        logic [4:0] r1, r2;
        bit u1, u2;
        int imm;
        op = m_instr[6:0];
        r1 = m_instr[19:15];
        r2 = m_instr[24:20];
        u1 = !(op inside {7'h37, 7'h17, 7'h6F, 7'h7F});
        u2 = op inside {7'h33, 7'h23, 7'h63};
        imm = $signed({m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21], 1'b0});
        e_stall = m_valid && ex_mem_read && (ex_rd != 0) && !ex_branch_taken &&
                  ((u1 && r1 == ex_rd) || (u2 && r2 == ex_rd));
        e_jump = 1'b0;
        e_next = '0;
        if (ex_branch_taken) begin
            e_jump = 1'b1;
            e_next = ex_target;
        end else if (m_valid && op == 7'h6F && m_age < 0) begin
            e_jump = 1'b1;
            e_next = m_pc + 32'(imm >>> 2);
        end
    end

    always @(posedge clk) begin
        bit flush, hold, halt_seen;
        if (rst) begin
            m_instr = NOP; m_valid = 0; m_pc = 0; m_npc = 0; m_age = -1; m_sc = 0; m_fc = 0;
        end else begin
            flush = e_jump || (m_age >= 0);
            hold = e_stall;
            halt_seen = (m_age < 0) && m_valid && (m_instr[6:0] == 7'h7F) && !ex_branch_taken;
            if (m_age < 0) begin
                if (e_stall) m_sc = m_sc + 1;
                if (e_jump)  m_fc = m_fc + 1;
            end
            if (halt_seen) m_age = 0;
            else if (m_age >= 0 && m_age < DRAIN_CYCLES) m_age = m_age + 1;
            if (flush) begin
                m_instr = NOP; m_valid = 0;
            end else if (!hold) begin
                m_instr = instruction; m_valid = !bubble; m_pc = PC; m_npc = nextPC;
            end
        end
    end

    // scoreboard compare
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall", 32'(stall), 32'(e_stall));
            cmp("id_bubble", 32'(id_bubble), 32'(e_stall));
            cmp("jump", 32'(jump), 32'(e_jump));
            cmp("next", next, e_next);
            cmp("id_valid", 32'(id_valid), 32'(m_valid));
            cmp("id_instruction", id_instruction, m_instr);
            cmp("id_PC", id_PC, m_pc);
            cmp("id_nextPC", id_nextPC, m_npc);
            cmp("hlt", 32'(hlt), 32'(m_age >= 0));
            cmp("halt_done", 32'(halt_done), 32'(m_age >= DRAIN_CYCLES));
`ifdef FETCH_PERF_COUNTERS_EN
            cmp("stall_count", stall_count, m_sc);
            cmp("flush_count", flush_count, m_fc);
`endif
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] ins, input logic [31:0] pc);
        instruction = ins;
        PC = pc;
        nextPC = pc + 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [0:8];
        logic [6:0] op;
        opcs = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        if ($urandom_range(0, 29) == 0) op = 7'h7F;
        else op = opcs[$urandom_range(0, 8)];
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        // reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        serve(32'h010000ef, 32'd1);
        @(negedge clk);
        cmp("lit_reset_valid", 32'(id_valid), 32'd0);
        cmp("lit_reset_instr", id_instruction, 32'h00000013);
        cmp("lit_reset_hlt", 32'(hlt), 32'd0);
        cmp("lit_reset_done", 32'(halt_done), 32'd0);

        // JAL redirect
        step();
        serve(32'h00000033, 32'd2);
        @(negedge clk);
        cmp("lit_jal_jump", 32'(jump), 32'd1);
        cmp("lit_jal_next", next, 32'd5);
        step();
        @(negedge clk);
        cmp("lit_jal_flush_instr", id_instruction, 32'h00000013);
        cmp("lit_jal_flush_valid", 32'(id_valid), 32'd0);

        // load-use on rs1
        serve(32'hfff50513, 32'd10);
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd10;
        serve(32'h00100093, 32'd11);
        @(negedge clk);
        cmp("lit_lu_stall", 32'(stall), 32'd1);
        cmp("lit_lu_bubble", 32'(id_bubble), 32'd1);
        step();
        @(negedge clk);
        cmp("lit_lu_hold_instr", id_instruction, 32'hfff50513);
        cmp("lit_lu_hold_pc", id_PC, 32'd10);
        ex_mem_read = 1'b0;
        @(negedge clk);
        cmp("lit_lu_release", 32'(stall), 32'd0);
        step();
        @(negedge clk);
        cmp("lit_lu_load_instr", id_instruction, 32'h00100093);
        cmp("lit_lu_load_pc", id_PC, 32'd11);

        // rd = x0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        @(negedge clk);
        cmp("lit_x0_stall", 32'(stall), 32'd0);

        // simultaneous EX redirect and JAL in ID
        ex_mem_read = 1'b0;
        serve(32'h010000ef, 32'd20);
        step();
        ex_branch_taken = 1'b1; ex_target = 32'd24; ex_mem_read = 1'b1; ex_rd = 5'd1;
        @(negedge clk);
        cmp("lit_sim_jump", 32'(jump), 32'd1);
        cmp("lit_sim_next", next, 32'd24);
        cmp("lit_sim_stall", 32'(stall), 32'd0);
        step();
        ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
        @(negedge clk);
        cmp("lit_sim_flush", 32'(id_valid), 32'd0);

        // bubble input
        serve(32'h00b02023, 32'd25);
        bubble = 1'b1;
        step();
        bubble = 1'b0;
        @(negedge clk);
        cmp("lit_bub_valid", 32'(id_valid), 32'd0);
        cmp("lit_bub_hlt", 32'(hlt), 32'd0);

        // HALT drain timing
        serve(32'h0000007F, 32'd30);
        step();
        serve(32'h00000013, 32'd31);
        @(negedge clk);
        cmp("lit_halt_early", 32'(hlt), 32'd0);
        step();
        @(negedge clk);
        cmp("lit_halt_hlt", 32'(hlt), 32'd1);
        cmp("lit_halt_done0", 32'(halt_done), 32'd0);
        step();
        step();
        @(negedge clk);
        cmp("lit_halt_done_p3", 32'(halt_done), 32'd0);
        step();
        @(negedge clk);
        cmp("lit_halt_done_p4", 32'(halt_done), 32'd1);
        step();
        step();
        @(negedge clk);
        cmp("lit_halt_sticky", 32'(halt_done), 32'd1);

        // reset during DRAIN
        rst = 1'b1;
        step();
        rst = 1'b0;
        serve(32'h0000007F, 32'd40);
        step();
        serve(32'h00000013, 32'd41);
        step();
        @(negedge clk);
        cmp("lit_drain_hlt", 32'(hlt), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        cmp("lit_drain_rst_hlt", 32'(hlt), 32'd0);
        cmp("lit_drain_rst_done", 32'(halt_done), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            instruction = rand_instr();
            PC = pc;
            nextPC = pc + 1;
            bubble = ($urandom_range(0, 4) == 0);
            ex_mem_read = ($urandom_range(0, 1) == 1);
            ex_rd = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_target = $urandom;
            rst = (m_age >= DRAIN_CYCLES && $urandom_range(0, 5) == 0) ||
                  ($urandom_range(0, 499) == 0);
            step();
        end

        rst = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Consumer side of the program-server fetch interface, and the block that drives the server's control inputs.
- Takes the served instruction, PC and nextPC into the IF/ID pipeline register.
- Resolves control flow: JAL in ID, taken branch/JALR from EX.
- Detects load-use hazards and the HALT word, and drives hlt, jump, next and stall back to the program server.
- Sits between the program server and the decode stage.

Parameters:
- NOP_INSTR, 32'h00000013, word loaded into IF/ID on flush/drain (addi x0,x0,0).
- HALT_OPCODE, 7'h7F, opcode field that requests halt.
- DRAIN_CYCLES, 3, cycles after HALT detection before halt_done (EX, MEM, WB drain).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high, sampled on rising edge of clk.
- instruction  in  32  instruction from program server.
- bubble  in  1  1 = served instruction is invalid.
- PC  in  32  word address of served instruction.
- nextPC  in  32  PC+1 from server.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of instruction in EX.
- ex_branch_taken  in  1  EX resolved taken branch or JALR.
- ex_target  in  32  absolute word address for EX redirect.
- hlt  out  1  registered halt to program server.
- jump  out  1  combinational redirect request.
- next  out  32  combinational redirect word address.
- stall  out  1  combinational load-use stall.
- id_valid  out  1  IF/ID contents valid.
- id_instruction  out  32  IF/ID instruction.
- id_PC  out  32  IF/ID PC.
- id_nextPC  out  32  IF/ID nextPC (JAL link value).
- id_bubble  out  1  insert bubble into ID/EX this cycle (= stall).
- halt_done  out  1  pipeline fully drained after HALT.

Behaviour:
- Reset (rst=1 at posedge):
  - id_instruction=NOP_INSTR, id_valid=0, id_PC=0, id_nextPC=0.
  - hlt=0, halt_done=0, state=RUN, drain counter=0.
  - Reset overrides all other events, including mid-DRAIN or in HALTED.
- Decode of id_instruction:
  - opc=[6:0], rs1=[19:15], rs2=[24:20].
  - rs1 used unless opc is 0x37, 0x17, 0x6F or HALT_OPCODE.
  - rs2 used only for opc 0x33, 0x23, 0x63.
- stall = id_valid & ex_mem_read & (ex_rd!=0) & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)). Forced 0 when ex_branch_taken=1.
- JAL target:
  - byte imm = sext{[31],[19:12],[20],[30:21],1'b0}, 21 bits.
  - target = id_PC + (imm >>> 2), 32-bit wrap-around add.
- Redirect priority, older instruction first:
  - ex_branch_taken=1: jump=1, next=ex_target.
  - else id_valid & opc==0x6F & state==RUN: jump=1, next=JAL target.
  - else jump=0, next=0.
- IF/ID update at each posedge, first match wins:
  1. jump=1 or state!=RUN: load NOP_INSTR, id_valid=0.
  2. stall=1: hold all IF/ID fields.
  3. Otherwise: load instruction/PC/nextPC, id_valid=~bubble.
- FSM:
  - RUN: if id_valid & opc==HALT_OPCODE & ~ex_branch_taken, go to DRAIN, set hlt=1, counter=0. A taken EX branch squashes the HALT.
  - DRAIN: counter increments each cycle. When counter==DRAIN_CYCLES-1, go to HALTED.
  - HALTED: halt_done=1, hlt stays 1; exit only by reset.
- Latency:
  - hlt rises 1 cycle after HALT reaches ID.
  - halt_done rises DRAIN_CYCLES+1 cycles after HALT reaches ID.
- Wrong-path JAL: a JAL in ID while its predecessor redirects from EX is flushed and does not redirect.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs stall_count[31:0] and flush_count[31:0], both reset to 0.
  - stall_count +1 per cycle with stall=1; flush_count +1 per cycle with jump=1.
  - Both wrap at 2^32 and freeze in DRAIN/HALTED.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- JAL redirect: id_PC=1, id_instruction=0x010000ef -> jump=1, next=5 that cycle; next cycle id_instruction=0x13, id_valid=0.
- Load-use, rs1: ex_mem_read=1, ex_rd=10, ID=0xfff50513 -> stall=1, id_bubble=1, IF/ID held. Then ex_mem_read=0 -> stall=0, IF/ID loads served instruction.
- Load-use, rd=x0: ex_mem_read=1, ex_rd=0, ID rs1=0 -> stall=0.
- Simultaneous redirects: ex_branch_taken=1, ex_target=24, ID holds JAL -> next=24, stall=0, IF/ID flushed.
- Halt: ID=0x0000007F, id_valid=1 -> hlt=1 next cycle; halt_done=1 exactly 4 cycles after detection, then stays 1. rst=1 during DRAIN -> hlt=0, halt_done=0 next cycle.
- Bubble input: bubble=1 with instruction=0x00b02023 -> id_valid=0 after clock; FSM state unaffected.
